// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int ZERO_IDX = 0;

    // Index width for a register count (ceil(log2(nreg)), minimum 1).
    function automatic int calc_aw(input int nreg);
        int aw;
        aw = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < nreg) begin
                aw = i + 1;
            end else begin
                aw = aw;
            end
        end
        return aw;
    endfunction

endpackage

// File: rtl/regfile_sb_checker.sv
// Invariants of the scoreboard state: count matches busy bits, x0 never busy.
module regfile_sb_checker
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    localparam int AW = calc_aw(NREG)
) (
    input logic            clk,
    input logic            rst_n,
    input logic [NREG-1:0] busy,
    input logic [AW:0]     pending_cnt
);

    a_cnt_matches_busy: assert property (@(posedge clk) disable iff (!rst_n)
        int'(pending_cnt) == $countones(busy));

    a_zero_never_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !busy[0]);

    a_cnt_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        int'(pending_cnt) <= NREG - 1);

endmodule

// File: rtl/regfile_scoreboard.sv
// Busy bits, allocation handshake and outstanding-write counter.
// Honours REGFILE_SB_BYPASS_EN: a same-cycle write hides the busy bit on a read port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    localparam int AW = calc_aw(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_idx,
    input  logic          alloc_valid,
    input  logic [AW-1:0] alloc_idx,
    input  logic [AW-1:0] rs1_idx,
    input  logic [AW-1:0] rs2_idx,
    output logic          alloc_ready,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic [AW:0]   pending_cnt
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic [AW:0]     cnt_r;
    logic [AW:0]     cnt_nxt_s;
    logic            alloc_fire_s;
    logic            wb_clr_s;
    logic            cnt_inc_s;
    logic            cnt_dec_s;

    // Handshake and event decode, all against the pre-edge busy bits.
    always_comb begin
        alloc_ready  = 1'b1;
        alloc_fire_s = 1'b0;
        wb_clr_s     = 1'b0;
        cnt_dec_s    = 1'b0;
        if (alloc_idx == AW'(ZERO_IDX)) begin
            alloc_ready = 1'b1;
        end else begin
            alloc_ready = ~busy_r[alloc_idx];
        end
        if (alloc_valid && alloc_ready && (alloc_idx != AW'(ZERO_IDX))) begin
            alloc_fire_s = 1'b1;
        end else begin
            alloc_fire_s = 1'b0;
        end
        if (wb_en && (wb_idx != AW'(ZERO_IDX))) begin
            wb_clr_s  = 1'b1;
            cnt_dec_s = busy_r[wb_idx];
        end else begin
            wb_clr_s  = 1'b0;
            cnt_dec_s = 1'b0;
        end
        // A firing allocation implies its bit was clear, so it always counts up.
        cnt_inc_s = alloc_fire_s;
    end

    // Next busy vector and count; a same-index allocate is applied after the clear so set wins.
    always_comb begin
        busy_nxt_s = busy_r;
        cnt_nxt_s  = cnt_r;
        if (wb_clr_s) begin
            busy_nxt_s[wb_idx] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (alloc_fire_s) begin
            busy_nxt_s[alloc_idx] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        case ({cnt_inc_s, cnt_dec_s})
            2'b10:   cnt_nxt_s = cnt_r + {{AW{1'b0}}, 1'b1};
            2'b01:   cnt_nxt_s = cnt_r - {{AW{1'b0}}, 1'b1};
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
            cnt_r  <= {(AW+1){1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    // Per-port busy view.
    always_comb begin
        rs1_busy = busy_r[rs1_idx];
        rs2_busy = busy_r[rs2_idx];
`ifdef REGFILE_SB_BYPASS_EN
        if (wb_clr_s && (wb_idx == rs1_idx)) begin
            rs1_busy = 1'b0;
        end else begin
            rs1_busy = busy_r[rs1_idx];
        end
        if (wb_clr_s && (wb_idx == rs2_idx)) begin
            rs2_busy = 1'b0;
        end else begin
            rs2_busy = busy_r[rs2_idx];
        end
`endif
    end

    assign pending_cnt = cnt_r;

    regfile_sb_checker #(.NREG(NREG)) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .busy        (busy_r),
        .pending_cnt (cnt_r)
    );

endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file with read-after-write scoreboard.
// Optional REGFILE_SB_BYPASS_EN forwards same-cycle writeback data to the read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    localparam int AW = calc_aw(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_idx,
    input  logic [XLEN-1:0] wb_data,
    input  logic            alloc_valid,
    input  logic [AW-1:0]   alloc_idx,
    output logic            alloc_ready,
    input  logic [AW-1:0]   rs1_idx,
    input  logic [AW-1:0]   rs2_idx,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [AW:0]     pending_cnt
);

    logic [XLEN-1:0] regs_r [NREG];
    logic            wb_hit_s;

    assign wb_hit_s = wb_en && (wb_idx != AW'(ZERO_IDX));

    // Data array: synchronous clear, x0 writes dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_hit_s) begin
            regs_r[wb_idx] <= wb_data;
        end
    end

    // Read port 1.
    always_comb begin
        rs1_data = {XLEN{1'b0}};
        if (rs1_idx == AW'(ZERO_IDX)) begin
            rs1_data = {XLEN{1'b0}};
`ifdef REGFILE_SB_BYPASS_EN
        end else if (wb_hit_s && (wb_idx == rs1_idx)) begin
            rs1_data = wb_data;
`endif
        end else begin
            rs1_data = regs_r[rs1_idx];
        end
    end

    // Read port 2.
    always_comb begin
        rs2_data = {XLEN{1'b0}};
        if (rs2_idx == AW'(ZERO_IDX)) begin
            rs2_data = {XLEN{1'b0}};
`ifdef REGFILE_SB_BYPASS_EN
        end else if (wb_hit_s && (wb_idx == rs2_idx)) begin
            rs2_data = wb_data;
`endif
        end else begin
            rs2_data = regs_r[rs2_idx];
        end
    end

    regfile_scoreboard #(.NREG(NREG)) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_en       (wb_en),
        .wb_idx      (wb_idx),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .rs1_idx     (rs1_idx),
        .rs2_idx     (rs2_idx),
        .alloc_ready (alloc_ready),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .pending_cnt (pending_cnt)
    );

endmodule
